// File: rtl/ahb_mem_slave_ctrl_if.sv
// AHB-Lite bus bundle between one master port and the memory slave controller.
interface ahb_mem_slave_ctrl_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_mem_slave_ctrl.sv
// AHB-Lite slave controller in front of the on-chip ROM and RAM macros.
// Address phase is decoded and latched on the accept edge; the data phase
// lasts W+1 cycles (W wait cycles) and illegal accesses get the two-cycle
// ERROR response without touching either memory.
module ahb_mem_slave_ctrl #(
  parameter logic [7:0]  ROM_REGION = 8'hA0,
  parameter logic [7:0]  RAM_REGION = 8'hB0,
  parameter int unsigned ROM_AW     = 24,
  parameter int unsigned RAM_AW     = 24,
  parameter int unsigned ROM_WAIT   = 2,
  parameter int unsigned RAM_WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ahb_mem_slave_ctrl_if.slave   bus,
  output logic                  rom_rd_en,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [31:0]           rom_rdata,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_be,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Counter load values: the counter runs W-1 down to 0, giving W wait cycles.
  localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT - 1);
  localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT - 1);

  // Byte lanes touched by an access of the given size at the given low address bits.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << lsb;
      3'd1:    be = lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Any decode-time reason the access must be answered with ERROR.
  function automatic logic access_error(input logic is_rom, input logic is_ram,
                                        input logic write, input logic [2:0] size,
                                        input logic [1:0] lsb);
    logic misalign;
    case (size)
      3'd0:    misalign = 1'b0;
      3'd1:    misalign = lsb[0];
      3'd2:    misalign = (lsb != 2'b00);
      default: misalign = 1'b1;
    endcase
    return (~is_rom & ~is_ram) | (is_rom & write) | misalign;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rom_sel_q, rom_sel_d;
  logic                write_q, write_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [3:0]          be_q, be_d;
  logic                rom_rd_en_q, rom_rd_en_d;
  logic                ram_rd_en_q, ram_rd_en_d;
  logic                ram_wr_en_q, ram_wr_en_d;
  logic                hready_q, hready_d;
  logic                hresp_q, hresp_d;

  logic                accept_s;
  logic                is_rom_s;
  logic                is_ram_s;
  logic                err_s;
  logic [3:0]          be_s;
  logic                unused_s;

  // hprot is carried on the bus but has no meaning for these memories.
  assign unused_s = ^bus.hprot;

  // Address-phase decode of the current bus request.
  always_comb begin
    accept_s = bus.hsel & bus.htrans[1] & bus.hready_in;
    is_rom_s = (bus.haddr[31:24] == ROM_REGION);
    is_ram_s = (bus.haddr[31:24] == RAM_REGION);
    err_s    = access_error(is_rom_s, is_ram_s, bus.hwrite, bus.hsize, bus.haddr[1:0]);
    be_s     = lane_enables(bus.hsize, bus.haddr[1:0]);
  end

  // Next-state, latched-request and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_sel_d   = rom_sel_q;
    write_d     = write_q;
    rom_addr_d  = rom_addr_q;
    ram_addr_d  = ram_addr_q;
    be_d        = be_q;
    rom_rd_en_d = 1'b0;
    ram_rd_en_d = 1'b0;
    ram_wr_en_d = 1'b0;
    hready_d    = 1'b1;
    hresp_d     = 1'b0;

    case (state_q)
      // IDLE, LAST and ERR2 all end with HREADY high, so each may take a new transfer.
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_d = ST_ERR1;
          end else begin
            state_d   = ST_WAIT;
            write_d   = bus.hwrite;
            rom_sel_d = is_rom_s;
            if (is_rom_s) begin
              cnt_d       = ROM_CNT;
              rom_addr_d  = bus.haddr[ROM_AW-1:0];
              rom_rd_en_d = 1'b1;
            end else begin
              cnt_d       = RAM_CNT;
              ram_addr_d  = bus.haddr[RAM_AW-1:0];
              be_d        = be_s;
              ram_rd_en_d = ~bus.hwrite;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_LAST;
          ram_wr_en_d = write_q & ~rom_sel_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_WAIT: begin
        hready_d = 1'b0;
        hresp_d  = 1'b0;
      end
      ST_ERR1: begin
        hready_d = 1'b0;
        hresp_d  = 1'b1;
      end
      ST_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rom_sel_q   <= 1'b0;
      write_q     <= 1'b0;
      rom_addr_q  <= '0;
      ram_addr_q  <= '0;
      be_q        <= 4'b0000;
      rom_rd_en_q <= 1'b0;
      ram_rd_en_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_sel_q   <= rom_sel_d;
      write_q     <= write_d;
      rom_addr_q  <= rom_addr_d;
      ram_addr_q  <= ram_addr_d;
      be_q        <= be_d;
      rom_rd_en_q <= rom_rd_en_d;
      ram_rd_en_q <= ram_rd_en_d;
      ram_wr_en_q <= ram_wr_en_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
    end
  end

  assign rom_rd_en      = rom_rd_en_q;
  assign rom_addr       = rom_addr_q;
  assign ram_rd_en      = ram_rd_en_q;
  assign ram_wr_en      = ram_wr_en_q;
  assign ram_be         = be_q;
  assign ram_addr       = ram_addr_q;
  // hwdata is only guaranteed stable in the last data-phase cycle, which is
  // exactly when ram_wr_en is high, so it passes straight through.
  assign ram_wdata      = bus.hwdata;
  assign bus.hready_out = hready_q;
  assign bus.hresp      = hresp_q;
  assign bus.hrdata     = (state_q == ST_LAST && !write_q) ?
                          (rom_sel_q ? rom_rdata : ram_rdata) : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_mem_slave_ctrl.sv
// Self-checking bench for ahb_mem_slave_ctrl: directed vector table,
// randomized transfers against a byte-level memory model, and hand-written
// back-to-back and reset-during-wait sequences.
module tb_ahb_mem_slave_ctrl;
  localparam int ROM_W = 2;
  localparam int RAM_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ahb_mem_slave_ctrl_if bus_if();

  logic        rom_rd_en;
  logic [23:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        ram_rd_en;
  logic        ram_wr_en;
  logic [3:0]  ram_be;
  logic [23:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        mem_clr;

  logic [31:0] ram_mem [0:255];
  logic [7:0]  ref_bytes [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        e_err;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vt [0:7];

  ahb_mem_slave_ctrl #(
    .ROM_REGION(8'hA0), .RAM_REGION(8'hB0), .ROM_AW(24), .RAM_AW(24),
    .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] rom_word(input logic [23:0] off);
    return {off[7:0], off} ^ 32'h3C5A_A5C3;
  endfunction

  // Memory macros with one-cycle synchronous read latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h0;
    end else if (ram_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (ram_be[k]) ram_mem[ram_addr[9:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
    if (rom_rd_en) rom_rdata <= rom_word(rom_addr);
    if (ram_rd_en) ram_rdata <= ram_mem[ram_addr[9:2]];
  end

  // ---------------- reference model ----------------
  function automatic logic exp_err_f(input logic [31:0] a, input logic w, input logic [2:0] sz);
    logic [7:0] top;
    int n;
    top = a[31:24];
    if (top != 8'hA0 && top != 8'hB0) return 1'b1;
    if (top == 8'hA0 && w) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    n = 1 << sz;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] exp_be_f(input logic [31:0] a, input logic [2:0] sz);
    logic [3:0] be;
    int n;
    be = 4'b0000;
    n = (sz > 3'd2) ? 4 : (1 << sz);
    for (int k = 0; k < n; k++) be[(int'(a[1:0]) + k) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_word(input logic [9:0] off);
    int w;
    w = int'(off) & ~3;
    return {ref_bytes[w+3], ref_bytes[w+2], ref_bytes[w+1], ref_bytes[w]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    int b;
    n = 1 << sz;
    for (int k = 0; k < n; k++) begin
      b = int'(a[9:0]) + k;
      ref_bytes[b] = wd[8*(b % 4) +: 8];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic rdy, input logic rsp,
                     input logic rrom, input logic rram, input logic wr);
    chk({nm, "/hready_out"}, {31'h0, bus_if.hready_out}, {31'h0, rdy});
    chk({nm, "/hresp"},      {31'h0, bus_if.hresp},      {31'h0, rsp});
    chk({nm, "/rom_rd_en"},  {31'h0, rom_rd_en},         {31'h0, rrom});
    chk({nm, "/ram_rd_en"},  {31'h0, ram_rd_en},         {31'h0, rram});
    chk({nm, "/ram_wr_en"},  {31'h0, ram_wr_en},         {31'h0, wr});
  endtask

  task automatic drive_idle();
    bus_if.hsel      = 1'b0;
    bus_if.haddr     = 32'h0;
    bus_if.htrans    = 2'd0;
    bus_if.hwrite    = 1'b0;
    bus_if.hsize     = 3'd0;
    bus_if.hprot     = 4'h0;
    bus_if.hready_in = 1'b1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
    bus_if.hsel      = 1'b1;
    bus_if.haddr     = a;
    bus_if.htrans    = 2'd2;
    bus_if.hwrite    = w;
    bus_if.hsize     = sz;
    bus_if.hprot     = 4'h3;
    bus_if.hready_in = 1'b1;
  endtask

  // One isolated transfer; called at posedge+1 with the slave idle.
  task automatic xfer(input string nm, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic e_err, input logic [3:0] e_be,
                      input logic [31:0] e_rd);
    int   wt;
    logic rom;
    rom = (a[31:24] == 8'hA0);
    wt  = rom ? ROM_W : RAM_W;
    drive_addr(a, w, sz);
    @(posedge clk); #1;
    drive_idle();
    bus_if.hwdata = wd;
    if (e_err) begin
      @(negedge clk); cyc({nm, "/err1"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc({nm, "/err2"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < wt; i++) begin
        @(negedge clk);
        cyc($sformatf("%s/wait%0d", nm, i), 1'b0, 1'b0,
            (i == 0) && !w && rom, (i == 0) && !w && !rom, 1'b0);
        if (i == 0 && !w && rom)  chk({nm, "/rom_addr"}, {8'h0, rom_addr}, {8'h0, a[23:0]});
        if (i == 0 && !w && !rom) chk({nm, "/ram_addr"}, {8'h0, ram_addr}, {8'h0, a[23:0]});
      end
      @(negedge clk);
      cyc({nm, "/last"}, 1'b1, 1'b0, 1'b0, 1'b0, w);
      if (w) begin
        chk({nm, "/ram_be"},    {28'h0, ram_be},   {28'h0, e_be});
        chk({nm, "/ram_addr"},  {8'h0, ram_addr},  {8'h0, a[23:0]});
        chk({nm, "/ram_wdata"}, ram_wdata,         wd);
      end else begin
        chk({nm, "/hrdata"}, bus_if.hrdata, e_rd);
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic [7:0]  top;
    logic        w;
    logic [2:0]  sz;
    logic        err;
    int          r;

    reset = 1'b1;
    mem_clr = 1'b1;
    drive_idle();
    bus_if.hwdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset/rom_addr", {8'h0, rom_addr}, 32'h0);
    chk("reset/ram_addr", {8'h0, ram_addr}, 32'h0);
    chk("reset/ram_be",   {28'h0, ram_be},  32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_clr = 1'b0;

    // Requests that must not be accepted: hready_in low, BUSY, hsel low.
    for (int c = 0; c < 3; c++) begin
      drive_addr(32'hB000_0000, 1'b0, 3'd2);
      if (c == 0) bus_if.hready_in = 1'b0;
      if (c == 1) bus_if.htrans = 2'd1;
      if (c == 2) bus_if.hsel = 1'b0;
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      cyc($sformatf("noaccept%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end

    // Directed vector table.
    vt[0] = '{32'hA000_0010, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 4'b1111};
    vt[1] = '{32'hB000_0006, 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0, 4'b1100};
    vt[2] = '{32'hA000_0000, 1'b1, 3'd2, 32'h1234_5678, 1'b1, 4'b1111};
    vt[3] = '{32'hC000_0000, 1'b0, 3'd2, 32'h0000_0000, 1'b1, 4'b1111};
    vt[4] = '{32'hB000_0002, 1'b0, 3'd2, 32'h0000_0000, 1'b1, 4'b1111};
    vt[5] = '{32'hB000_0000, 1'b0, 3'd3, 32'h0000_0000, 1'b1, 4'b1111};
    vt[6] = '{32'hB000_0001, 1'b1, 3'd0, 32'h0000_AB00, 1'b0, 4'b0010};
    vt[7] = '{32'hB000_0004, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      erd = (vt[i].addr[31:24] == 8'hA0) ? rom_word(vt[i].addr[23:0]) : ref_word(vt[i].addr[9:0]);
      xfer($sformatf("vec%0d", i), vt[i].addr, vt[i].wr, vt[i].sz, vt[i].wd,
           vt[i].e_err, vt[i].e_be, erd);
      if (!vt[i].e_err && vt[i].wr) ref_write(vt[i].addr, vt[i].sz, vt[i].wd);
    end

    // Randomized transfers against the model.
    for (int n = 0; n < 60; n++) begin
      r   = int'($urandom_range(0, 9));
      top = (r < 4) ? 8'hA0 : ((r < 9) ? 8'hB0 : 8'hC3);
      a   = {top, 14'h0, 10'($urandom_range(0, 1023))};
      w   = 1'($urandom_range(0, 1));
      if (top == 8'hA0) w = ($urandom_range(0, 4) == 0);
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wd  = $urandom;
      err = exp_err_f(a, w, sz);
      erd = (top == 8'hA0) ? rom_word(a[23:0]) : ref_word(a[9:0]);
      xfer($sformatf("rnd%0d", n), a, w, sz, wd, err, exp_be_f(a, sz), erd);
      if (!err && w) ref_write(a, sz, wd);
    end

    // Back-to-back RAM reads, second accepted in LAST of the first.
    xfer("b2b_init0", 32'hB000_0000, 1'b1, 3'd2, 32'h1122_3344, 1'b0, 4'b1111, 32'h0);
    ref_write(32'hB000_0000, 3'd2, 32'h1122_3344);
    xfer("b2b_init1", 32'hB000_0004, 1'b1, 3'd2, 32'h5566_7788, 1'b0, 4'b1111, 32'h0);
    ref_write(32'hB000_0004, 3'd2, 32'h5566_7788);
    drive_addr(32'hB000_0000, 1'b0, 3'd2);
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < RAM_W; i++) begin
      @(negedge clk);
      cyc($sformatf("b2b_a_wait%0d", i), 1'b0, 1'b0, 1'b0, (i == 0), 1'b0);
      if (i == 0) chk("b2b_a/ram_addr", {8'h0, ram_addr}, 32'h0000_0000);
    end
    @(posedge clk); #1;
    drive_addr(32'hB000_0004, 1'b0, 3'd2);
    @(negedge clk);
    cyc("b2b_a_last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_a/hrdata", bus_if.hrdata, ref_word(10'h000));
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < RAM_W; i++) begin
      @(negedge clk);
      cyc($sformatf("b2b_b_wait%0d", i), 1'b0, 1'b0, 1'b0, (i == 0), 1'b0);
      if (i == 0) chk("b2b_b/ram_addr", {8'h0, ram_addr}, 32'h0000_0004);
    end
    @(negedge clk);
    cyc("b2b_b_last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_b/hrdata", bus_if.hrdata, ref_word(10'h004));
    @(posedge clk); #1;

    // Reset during WAIT of a write: abandoned, no write strobe, ready at once.
    xfer("rst_init", 32'hB000_0010, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0);
    ref_write(32'hB000_0010, 3'd2, 32'hCAFE_F00D);
    drive_addr(32'hB000_0010, 1'b1, 3'd2);
    @(posedge clk); #1;
    drive_idle();
    bus_if.hwdata = 32'h0BAD_0BAD;
    @(negedge clk);
    cyc("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("rst_async/hready_out", {31'h0, bus_if.hready_out}, 32'h1);
    chk("rst_async/hresp",      {31'h0, bus_if.hresp},      32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cyc($sformatf("rst_after%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    xfer("rst_readback", 32'hB000_0010, 1'b0, 3'd2, 32'h0, 1'b0, 4'b1111, ref_word(10'h010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
